// File: rtl/thee_nco_multi.sv
// thee_nco_multi: multi-channel NCO, slew-limited retuning, per-channel lock.
// Optional phase dither: define THEE_NCO_DITHER_EN.
module thee_nco_multi #(
  parameter int NCH        = 4,
  parameter int ACC_W      = 16,
  parameter int CODE_W     = 8,
  parameter int CODE_MIN   = -100,
  parameter int CODE_MAX   = 100,
  parameter int FCW_MIN    = 1024,
  parameter int FCW_MAX    = 2048,
  parameter int SLEW_STEP  = 64,
  parameter int SETTLE_CYC = 4
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 ctrl_valid,
  output logic                                 ctrl_ready,
  input  logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] ctrl_ch,
  input  logic signed [CODE_W-1:0]             ctrl_code,
  input  logic [NCH-1:0]                       en,
  output logic [NCH-1:0]                       clk_out,
  output logic [NCH-1:0]                       lock,
  output logic [NCH*ACC_W-1:0]                 fcw_cur
);

  localparam int CH_W   = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int SPAN   = CODE_MAX - CODE_MIN;
  localparam int DF     = FCW_MAX - FCW_MIN;
  localparam int SPAN_W = $clog2(SPAN + 1) + 1;
  localparam int PROD_W = SPAN_W + ACC_W;
  localparam int CNT_W  = $clog2(SETTLE_CYC + 1);

  localparam logic [ACC_W-1:0] STEP = ACC_W'(SLEW_STEP);
  localparam logic [ACC_W-1:0] FMIN = ACC_W'(FCW_MIN);
  localparam logic [CNT_W-1:0] CLAST = CNT_W'(SETTLE_CYC - 1);

  if (CODE_MAX <= CODE_MIN) begin : g_bad_code
    $error("thee_nco_multi: CODE_MAX must exceed CODE_MIN");
  end
  if (FCW_MAX < FCW_MIN) begin : g_bad_fcw
    $error("thee_nco_multi: FCW_MAX below FCW_MIN");
  end
  if (FCW_MAX >= (1 << (ACC_W - 1))) begin : g_bad_nyq
    $error("thee_nco_multi: FCW_MAX must be below 2^(ACC_W-1)");
  end
  if (SLEW_STEP == 0) begin : g_bad_slew
    $error("thee_nco_multi: SLEW_STEP must be nonzero");
  end
  if (SETTLE_CYC == 0) begin : g_bad_settle
    $error("thee_nco_multi: SETTLE_CYC must be nonzero");
  end

  typedef enum logic [1:0] {
    ST_OFF,
    ST_SLEW,
    ST_LOCK
  } st_e;

  logic              s1_v_q;
  logic              s2_v_q;
  logic [CH_W-1:0]   s1_ch_q;
  logic [CH_W-1:0]   s2_ch_q;
  logic [PROD_W-1:0] s1_prod_q;
  logic [PROD_W-1:0] s1_prod_d;
  logic [ACC_W-1:0]  s2_fcw_q;
  logic [ACC_W-1:0]  s2_fcw_d;
  logic              xfer;
  int                code_s;
  int                code_c;

  assign ctrl_ready = !(s1_v_q || s2_v_q);
  assign xfer = ctrl_valid && ctrl_ready;

  // stage 1 math: clamp the code, scale its offset by the fcw span
  always_comb begin
    code_s = 32'(ctrl_code);
    code_c = code_s;
    if (code_s < CODE_MIN) code_c = CODE_MIN;
    if (code_s > CODE_MAX) code_c = CODE_MAX;
    s1_prod_d = PROD_W'(code_c - CODE_MIN) * PROD_W'(DF);
  end

  // stage 2 math: truncating divide by code span, offset by FCW_MIN
  always_comb begin
    s2_fcw_d = ACC_W'(s1_prod_q / PROD_W'(SPAN)) + FMIN;
  end

  // mapping pipeline registers; ready is low while either stage is busy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v_q    <= 1'b0;
      s2_v_q    <= 1'b0;
      s1_ch_q   <= '0;
      s2_ch_q   <= '0;
      s1_prod_q <= '0;
      s2_fcw_q  <= FMIN;
    end else begin
      s1_v_q <= xfer;
      s2_v_q <= s1_v_q;
      if (xfer) begin
        s1_ch_q   <= ctrl_ch;
        s1_prod_q <= s1_prod_d;
      end
      if (s1_v_q) begin
        s2_ch_q  <= s1_ch_q;
        s2_fcw_q <= s2_fcw_d;
      end
    end
  end

`ifdef THEE_NCO_DITHER_EN
  logic [15:0] lfsr_q;

  // shared maximal-length Galois LFSR, x^16+x^14+x^13+x^11+1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= 16'hACE1;
    else lfsr_q <= {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
  end
`endif

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    st_e              st_q;
    logic [ACC_W-1:0] fcw_q;
    logic [ACC_W-1:0] tgt_q;
    logic [ACC_W-1:0] phase_q;
    logic [ACC_W-1:0] slew_d;
    logic [ACC_W-1:0] inc;
    logic [CNT_W-1:0] cnt_q;
    logic             lock_q;
    logic             wr;
    logic             wr_new;
    logic             on_tgt;

    assign wr     = s2_v_q && (s2_ch_q == CH_W'(i));
    assign wr_new = wr && (s2_fcw_q != tgt_q);
    assign on_tgt = (fcw_q == tgt_q);

`ifdef THEE_NCO_DITHER_EN
    assign inc = fcw_q + ACC_W'(lfsr_q[i % 16]);
`else
    assign inc = fcw_q;
`endif

    // one bounded step toward the target, landing exactly on it
    always_comb begin
      slew_d = fcw_q;
      if (fcw_q < tgt_q) begin
        slew_d = (tgt_q - fcw_q > STEP) ? fcw_q + STEP : tgt_q;
      end else if (fcw_q > tgt_q) begin
        slew_d = (fcw_q - tgt_q > STEP) ? fcw_q - STEP : tgt_q;
      end
    end

    // channel FSM; a low enable forces OFF whatever else happens
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        st_q    <= ST_OFF;
        fcw_q   <= FMIN;
        tgt_q   <= FMIN;
        phase_q <= '0;
        cnt_q   <= '0;
        lock_q  <= 1'b0;
      end else begin
        if (wr) tgt_q <= s2_fcw_q;
        if (!en[i]) begin
          st_q    <= ST_OFF;
          fcw_q   <= FMIN;
          phase_q <= '0;
          cnt_q   <= '0;
          lock_q  <= 1'b0;
        end else begin
          unique case (st_q)
            ST_OFF: begin
              st_q  <= ST_SLEW;
              cnt_q <= '0;
            end
            ST_SLEW: begin
              phase_q <= phase_q + inc;
              fcw_q   <= slew_d;
              if (wr_new || !on_tgt) begin
                cnt_q <= '0;
              end else if (cnt_q == CLAST) begin
                st_q   <= ST_LOCK;
                lock_q <= 1'b1;
                cnt_q  <= '0;
              end else begin
                cnt_q <= cnt_q + CNT_W'(1);
              end
            end
            ST_LOCK: begin
              phase_q <= phase_q + inc;
              if (wr_new) begin
                st_q   <= ST_SLEW;
                lock_q <= 1'b0;
                cnt_q  <= '0;
              end
            end
            default: begin
              st_q   <= ST_OFF;
              lock_q <= 1'b0;
            end
          endcase
        end
      end
    end

    assign clk_out[i] = phase_q[ACC_W-1];
    assign lock[i]    = lock_q;
    assign fcw_cur[i*ACC_W +: ACC_W] = fcw_q;
  end

endmodule

// File: tb/tb_thee_nco_multi.sv
// tb_thee_nco_multi: directed scenarios plus random traffic
// against a cycle-level behavioural model of the oscillator bank.
module tb_thee_nco_multi;

  localparam int NCH   = 5;
  localparam int ACC_W = 16;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    ctrl_valid;
  logic                    ctrl_ready;
  logic [2:0]              ctrl_ch;
  logic signed [7:0]       ctrl_code;
  logic [NCH-1:0]          en;
  logic [NCH-1:0]          clk_out;
  logic [NCH-1:0]          lock;
  logic [NCH*ACC_W-1:0]    fcw_cur;

  int total = 0;
  int bad   = 0;

  int m_on[NCH];
  int m_lock[NCH];
  int m_fcw[NCH];
  int m_tgt[NCH];
  int m_ph[NCH];
  int m_eq[NCH];
  int m_busy;
  int m_pch;
  int m_pfcw;

  thee_nco_multi #(.NCH(NCH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ctrl_valid (ctrl_valid),
    .ctrl_ready (ctrl_ready),
    .ctrl_ch    (ctrl_ch),
    .ctrl_code  (ctrl_code),
    .en         (en),
    .clk_out    (clk_out),
    .lock       (lock),
    .fcw_cur    (fcw_cur)
  );

  always #5 clk = ~clk;

  function automatic int map_code(input int c);
    int cc;
    cc = (c < -100) ? -100 : ((c > 100) ? 100 : c);
    return 1024 + ((cc + 100) * 1024) / 200;
  endfunction

  function automatic int fcw_of(input int ch);
    return int'(fcw_cur[ch*ACC_W +: ACC_W]);
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_on[c] = 0; m_lock[c] = 0; m_fcw[c] = 1024;
      m_tgt[c] = 1024; m_ph[c] = 0; m_eq[c] = 0;
    end
    m_busy = 0; m_pch = 0; m_pfcw = 1024;
  endtask

  task automatic tick();
    bit rdy_pre;
    bit wr;
    int wch;
    int wfcw;
    @(posedge clk);
    rdy_pre = (m_busy == 0);
    wr = 0; wch = m_pch; wfcw = m_pfcw;
    if (m_busy > 0) begin
      m_busy--;
      wr = (m_busy == 0);
    end
    if (ctrl_valid && rdy_pre) begin
      m_busy = 2;
      m_pch  = int'(ctrl_ch);
      m_pfcw = map_code(int'(ctrl_code));
    end
    for (int c = 0; c < NCH; c++) begin
      bit hit;
      int d;
      hit = wr && (wch == c);
      if (!en[c]) begin
        m_on[c] = 0; m_lock[c] = 0; m_fcw[c] = 1024;
        m_ph[c] = 0; m_eq[c] = 0;
      end else if (m_on[c] == 0) begin
        m_on[c] = 1; m_eq[c] = 0;
      end else begin
        m_ph[c] = (m_ph[c] + m_fcw[c]) % 65536;
        if (m_fcw[c] == m_tgt[c]) m_eq[c]++;
        else m_eq[c] = 0;
        d = m_tgt[c] - m_fcw[c];
        if (d > 64) d = 64;
        if (d < -64) d = -64;
        m_fcw[c] += d;
        if (hit && wfcw != m_tgt[c]) begin
          m_lock[c] = 0; m_eq[c] = 0;
        end else if (m_eq[c] >= 4) begin
          m_lock[c] = 1;
        end
      end
      if (hit) m_tgt[c] = wfcw;
    end
    #1;
  endtask

  task automatic send(input int ch, input int code);
    ctrl_valid = 1'b1;
    ctrl_ch    = 3'(ch);
    ctrl_code  = 8'(code);
    tick();
    ctrl_valid = 1'b0;
    tick();
    tick();
  endtask

  task automatic wait_lock(input int ch, input int maxc, output int n);
    n = 0;
    while (!lock[ch] && n < maxc) begin
      tick();
      n++;
    end
  endtask

  // from a rising edge of clk_out[ch], span nper periods
  task automatic measure(input int ch, input int nper,
                         output int hi, output int len);
    bit p;
    int guard;
    int rises;
    hi = 0; len = 0; rises = 0;
    p = clk_out[ch];
    tick();
    guard = 1;
    while (!(p == 1'b0 && clk_out[ch] == 1'b1) && guard < 300) begin
      p = clk_out[ch];
      tick();
      guard++;
    end
    while (rises < nper && guard < 600) begin
      if (clk_out[ch] && rises == 0) hi++;
      p = clk_out[ch];
      tick();
      len++;
      guard++;
      if (!p && clk_out[ch]) rises++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ctrl_valid = 1'b0; ctrl_ch = '0; ctrl_code = '0; en = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (ctrl_ready !== 1'b1) begin
      bad++; $display("FAIL reset_ready got=%b exp=1", ctrl_ready);
    end
    total++;
    if (lock !== '0) begin
      bad++; $display("FAIL reset_lock got=%b exp=0", lock);
    end
    total++;
    if (clk_out !== '0) begin
      bad++; $display("FAIL reset_clk_out got=%b exp=0", clk_out);
    end
    for (int c = 0; c < NCH; c++) begin
      total++;
      if (fcw_of(c) !== 1024) begin
        bad++; $display("FAIL reset_fcw ch%0d got=%0d exp=1024", c, fcw_of(c));
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_lock_ch0();
    int n;
    int k;
    int hi;
    int len;
    en = 5'b00001;
    tick();
    wait_lock(0, 20, k);
    n = k + 1;
    total++;
    if (n !== 5) begin
      bad++; $display("FAIL lock_edge got=%0d exp=5", n);
    end
    total++;
    if (fcw_of(0) !== 1024) begin
      bad++; $display("FAIL lock_fcw got=%0d exp=1024", fcw_of(0));
    end
    measure(0, 1, hi, len);
    total++;
    if (len !== 64) begin
      bad++; $display("FAIL period_1024 got=%0d exp=64", len);
    end
    total++;
    if (hi !== 32) begin
      bad++; $display("FAIL duty_1024 got=%0d exp=32", hi);
    end
    total++;
    if (clk_out[4:1] !== 4'b0000) begin
      bad++; $display("FAIL idle_clk got=%b exp=0000", clk_out[4:1]);
    end
  endtask

  task automatic test_retune();
    int n;
    int hi;
    int len;
    total++;
    if (ctrl_ready !== 1'b1) begin
      bad++; $display("FAIL retune_ready0 got=%b exp=1", ctrl_ready);
    end
    ctrl_valid = 1'b1; ctrl_ch = 3'd0; ctrl_code = 8'sd0;
    tick();
    ctrl_valid = 1'b0;
    total++;
    if (ctrl_ready !== 1'b0) begin
      bad++; $display("FAIL retune_busy1 got=%b exp=0", ctrl_ready);
    end
    tick();
    total++;
    if (ctrl_ready !== 1'b0 || lock[0] !== 1'b1) begin
      bad++;
      $display("FAIL retune_busy2 got rdy=%b lock=%b exp rdy=0 lock=1",
               ctrl_ready, lock[0]);
    end
    tick();
    total++;
    if (ctrl_ready !== 1'b1 || lock[0] !== 1'b0 || fcw_of(0) !== 1024) begin
      bad++;
      $display("FAIL retune_write got rdy=%b lock=%b fcw=%0d exp 1 0 1024",
               ctrl_ready, lock[0], fcw_of(0));
    end
    for (int k = 1; k <= 8; k++) begin
      tick();
      total++;
      if (fcw_of(0) !== 1024 + 64 * k) begin
        bad++;
        $display("FAIL retune_step%0d got=%0d exp=%0d", k, fcw_of(0), 1024 + 64 * k);
      end
    end
    wait_lock(0, 20, n);
    total++;
    if (n !== 4) begin
      bad++; $display("FAIL relock_delay got=%0d exp=4", n);
    end
    measure(0, 3, hi, len);
    total++;
    if (len !== 128) begin
      bad++; $display("FAIL period3_1536 got=%0d exp=128", len);
    end
    measure(0, 1, hi, len);
    total++;
    if (len !== 42 && len !== 43) begin
      bad++; $display("FAIL period_1536 got=%0d exp=42or43", len);
    end
  endtask

  task automatic test_clamp();
    int n;
    int hi;
    int len;
    en = 5'b00011;
    send(1, -128);
    wait_lock(1, 20, n);
    total++;
    if (lock[1] !== 1'b1 || fcw_of(1) !== 1024) begin
      bad++;
      $display("FAIL clamp_low got lock=%b fcw=%0d exp 1 1024", lock[1], fcw_of(1));
    end
    send(1, 127);
    total++;
    if (lock[1] !== 1'b0) begin
      bad++; $display("FAIL clamp_unlock got=%b exp=0", lock[1]);
    end
    wait_lock(1, 40, n);
    total++;
    if (lock[1] !== 1'b1 || fcw_of(1) !== 2048) begin
      bad++;
      $display("FAIL clamp_high got lock=%b fcw=%0d exp 1 2048", lock[1], fcw_of(1));
    end
    measure(1, 1, hi, len);
    total++;
    if (len !== 32 || hi !== 16) begin
      bad++; $display("FAIL period_2048 got len=%0d hi=%0d exp 32 16", len, hi);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    bit exp_rdy[4];
    en = 5'b00111;
    exp_rdy = '{1'b0, 1'b0, 1'b1, 1'b0};
    ctrl_valid = 1'b1; ctrl_ch = 3'd5; ctrl_code = 8'sd7;
    for (int k = 0; k < 4; k++) begin
      tick();
      ctrl_ch = 3'd2; ctrl_code = 8'sd50;
      if (k == 3) ctrl_valid = 1'b0;
      total++;
      if (ctrl_ready !== exp_rdy[k]) begin
        bad++; $display("FAIL b2b_ready%0d got=%b exp=%b", k, ctrl_ready, exp_rdy[k]);
      end
    end
    tick();
    tick();
    wait_lock(2, 40, n);
    total++;
    if (lock[2] !== 1'b1 || fcw_of(2) !== 1792) begin
      bad++;
      $display("FAIL b2b_ch2 got lock=%b fcw=%0d exp 1 1792", lock[2], fcw_of(2));
    end
    total++;
    if (fcw_of(0) !== 1536 || fcw_of(1) !== 2048 || lock[1:0] !== 2'b11) begin
      bad++;
      $display("FAIL b2b_discard got fcw0=%0d fcw1=%0d lock=%b exp 1536 2048 11",
               fcw_of(0), fcw_of(1), lock[1:0]);
    end
  endtask

  task automatic test_en_drop();
    send(0, 100);
    repeat (3) tick();
    total++;
    if (fcw_of(0) !== 1728) begin
      bad++; $display("FAIL drop_midslew got=%0d exp=1728", fcw_of(0));
    end
    en[0] = 1'b0;
    tick();
    total++;
    if (clk_out[0] !== 1'b0 || lock[0] !== 1'b0 || fcw_of(0) !== 1024) begin
      bad++;
      $display("FAIL drop_off got clk=%b lock=%b fcw=%0d exp 0 0 1024",
               clk_out[0], lock[0], fcw_of(0));
    end
    en[0] = 1'b1;
    tick();
    tick();
    total++;
    if (fcw_of(0) !== 1088) begin
      bad++; $display("FAIL drop_reslew got=%0d exp=1088", fcw_of(0));
    end
  endtask

  task automatic test_async_reset();
    int n;
    ctrl_valid = 1'b1; ctrl_ch = 3'd1; ctrl_code = 8'sd0;
    tick();
    ctrl_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    total++;
    if (ctrl_ready !== 1'b1 || lock !== '0 || clk_out !== '0) begin
      bad++;
      $display("FAIL areset_out got rdy=%b lock=%b clk=%b exp 1 0 0",
               ctrl_ready, lock, clk_out);
    end
    total++;
    if (fcw_of(0) !== 1024 || fcw_of(1) !== 1024 || fcw_of(2) !== 1024) begin
      bad++;
      $display("FAIL areset_fcw got %0d %0d %0d exp 1024", fcw_of(0), fcw_of(1), fcw_of(2));
    end
    @(negedge clk);
    rst_n = 1'b1;
    wait_lock(1, 20, n);
    total++;
    if (n !== 5 || fcw_of(1) !== 1024) begin
      bad++;
      $display("FAIL areset_lost got n=%0d fcw=%0d exp 5 1024", n, fcw_of(1));
    end
  endtask

  task automatic test_random();
    en = 5'b11111;
    for (int cyc = 0; cyc < 400; cyc++) begin
      ctrl_valid = ($urandom_range(0, 3) == 0);
      ctrl_ch    = 3'($urandom_range(0, 7));
      ctrl_code  = 8'($urandom);
      if ($urandom_range(0, 15) == 0) en[$urandom_range(0, NCH - 1)] ^= 1'b1;
      tick();
      total++;
      if (ctrl_ready !== (m_busy == 0)) begin
        bad++; $display("FAIL rand_ready cyc%0d got=%b exp=%b", cyc, ctrl_ready, m_busy == 0);
      end
      for (int c = 0; c < NCH; c++) begin
        total++;
        if (fcw_of(c) !== m_fcw[c]) begin
          bad++; $display("FAIL rand_fcw ch%0d cyc%0d got=%0d exp=%0d", c, cyc, fcw_of(c), m_fcw[c]);
        end
        total++;
        if (lock[c] !== (m_lock[c] != 0)) begin
          bad++; $display("FAIL rand_lock ch%0d cyc%0d got=%b exp=%0d", c, cyc, lock[c], m_lock[c]);
        end
        total++;
        if (clk_out[c] !== (m_ph[c] >= 32768)) begin
          bad++; $display("FAIL rand_clk ch%0d cyc%0d got=%b exp_phase=%0d", c, cyc, clk_out[c], m_ph[c]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_lock_ch0();
    test_retune();
    test_clamp();
    test_back_to_back();
    test_en_drop();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
